// File: rtl/uart_spi_pkg.sv
// Shared types and constants for the UART<->SPI-slave bridge.
package uart_spi_pkg;

  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE1 = 2'd1,
    MODE2 = 2'd2,
    MODE3 = 2'd3
  } spi_mode_e;

  // Bit positions inside err_flags
  localparam int ERR_TX_OVF = 0;
  localparam int ERR_RX_OVF = 1;
  localparam int ERR_ABORT  = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } shift_state_e;

  // Idle level of sclk for a given mode
  function automatic logic mode_cpol(input spi_mode_e m);
    return (m == MODE2) || (m == MODE3);
  endfunction

  // Sampling happens on the rising edge when CPOL equals CPHA
  function automatic logic mode_samples_rising(input spi_mode_e m);
    return (m == MODE0) || (m == MODE3);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and occupancy count.
// A push into a full FIFO only lands when a pop happens in the same cycle.
module sync_fifo
  import uart_spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_spi_bridge.sv
// UART<->SPI-slave bridge: UART bytes are queued and shifted out on miso,
// words captured on mosi are queued towards the UART transmitter.
//
// state  | meaning
// IDLE   | cs_bar high, miso held 0, no shifting
// ACTIVE | frame in progress, sample/shift edges processed
module uart_spi_bridge
  import uart_spi_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                FIFO_DEPTH = 8,
  parameter int                SPI_MODE   = 0,
  parameter bit                MSB_FIRST  = 1'b1,
  parameter logic [DATA_W-1:0] FILL_WORD  = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             uart_rx_data,
  input  logic                          uart_rx_valid,
  output logic [DATA_W-1:0]             uart_tx_data,
  output logic                          uart_tx_valid,
  input  logic                          uart_tx_ready,
  input  logic                          cs_bar,
  input  logic                          sclk,
  input  logic                          mosi,
  output logic                          miso,
  output logic                          spi_rx_valid,
  output logic                          spi_tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic [2:0]                    err_flags,
  input  logic                          err_clear
);

  localparam int              CW          = $clog2(DATA_W + 1);
  localparam logic [CW-1:0]   LAST_BIT    = CW'(DATA_W - 1);
  localparam spi_mode_e       MODE        = spi_mode_e'(SPI_MODE[1:0]);
  localparam bit              CPOL        = mode_cpol(MODE);
  localparam bit              SAMPLE_RISE = mode_samples_rising(MODE);

  shift_state_e      state;
  shift_state_e      state_nxt;

  logic [1:0]        cs_sync;
  logic [1:0]        sclk_sync;
  logic [1:0]        mosi_sync;
  logic              cs_d;
  logic              sclk_d;
  logic              cs_fall;
  logic              cs_rise;
  logic              sample_edge;
  logic              shift_edge;

  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] rx_word;
  logic [DATA_W-1:0] load_word;
  logic [CW-1:0]     bit_cnt;
  logic              word_pulse;

  logic              frame_start;
  logic              in_frame;
  logic              sample_hit;
  logic              word_end;
  logic              load;
  logic              abort;

  logic [DATA_W-1:0] tx_head;
  logic              tx_full;
  logic              tx_empty;
  logic              tx_pop;
  logic              rx_full;
  logic              rx_empty;
  logic              rx_pop;
  logic [2:0]        err_set;

  // Two-flop synchronisers plus one history stage for edge detection;
  // sclk history starts at its idle level so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync   <= 2'b11;
      sclk_sync <= {2{CPOL}};
      mosi_sync <= 2'b00;
      cs_d      <= 1'b1;
      sclk_d    <= CPOL;
    end else begin
      cs_sync   <= {cs_sync[0], cs_bar};
      sclk_sync <= {sclk_sync[0], sclk};
      mosi_sync <= {mosi_sync[0], mosi};
      cs_d      <= cs_sync[1];
      sclk_d    <= sclk_sync[1];
    end
  end

  assign cs_fall     = cs_d & ~cs_sync[1];
  assign cs_rise     = ~cs_d & cs_sync[1];
  assign sample_edge = SAMPLE_RISE ? (sclk_sync[1] & ~sclk_d) : (~sclk_sync[1] & sclk_d);
  assign shift_edge  = SAMPLE_RISE ? (~sclk_sync[1] & sclk_d) : (sclk_sync[1] & ~sclk_d);

  // Shifter state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Shifter next-state: frames are bounded purely by chip select
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = ACTIVE;
      ACTIVE:  if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign frame_start = (state == IDLE) && cs_fall;
  assign in_frame    = (state == ACTIVE) && !cs_rise;
  assign sample_hit  = in_frame && sample_edge;
  assign word_end    = sample_hit && (bit_cnt == LAST_BIT);
  assign load        = frame_start || word_end;
  assign abort       = (state == ACTIVE) && cs_rise && (bit_cnt != '0);
  assign tx_pop      = load && !tx_empty;
  assign load_word   = tx_empty ? FILL_WORD : tx_head;
  assign rx_next     = MSB_FIRST ? {rx_shift[DATA_W-2:0], mosi_sync[1]}
                                 : {mosi_sync[1], rx_shift[DATA_W-1:1]};
  assign miso        = (state == ACTIVE) ? (MSB_FIRST ? tx_shift[DATA_W-1] : tx_shift[0]) : 1'b0;

  // Shift datapath. A shift edge seen while bit_cnt is 0 only presents the
  // freshly loaded first bit, which covers both the CPHA=1 leading edge and
  // the trailing edge right after a word-boundary reload.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_shift   <= '0;
      rx_shift   <= '0;
      rx_word    <= '0;
      bit_cnt    <= '0;
      word_pulse <= 1'b0;
    end else begin
      word_pulse <= word_end;
      if (word_end) rx_word <= rx_next;
      if (frame_start) begin
        tx_shift <= load_word;
        rx_shift <= '0;
        bit_cnt  <= '0;
      end else if ((state == ACTIVE) && cs_rise) begin
        bit_cnt  <= '0;
      end else if (sample_hit) begin
        rx_shift <= rx_next;
        if (word_end) begin
          bit_cnt  <= '0;
          tx_shift <= load_word;
        end else begin
          bit_cnt  <= bit_cnt + CW'(1);
        end
      end else if (in_frame && shift_edge && (bit_cnt != '0)) begin
        tx_shift <= MSB_FIRST ? {tx_shift[DATA_W-2:0], 1'b0} : {1'b0, tx_shift[DATA_W-1:1]};
      end
    end
  end

  assign spi_rx_valid = word_pulse;
  assign spi_tx_done  = word_pulse;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (uart_rx_valid),
    .push_data (uart_rx_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level)
  );

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (word_pulse),
    .push_data (rx_word),
    .pop       (rx_pop),
    .head      (uart_tx_data),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level)
  );

  assign uart_tx_valid = ~rx_empty;
  assign rx_pop        = uart_tx_valid && uart_tx_ready;

  // Collect error events for this cycle
  always_comb begin
    err_set             = '0;
    err_set[ERR_TX_OVF] = uart_rx_valid && tx_full && !tx_pop;
    err_set[ERR_RX_OVF] = word_pulse && rx_full && !rx_pop;
    err_set[ERR_ABORT]  = abort;
  end

  // Sticky flags; a clear wins over a simultaneous new event
  always_ff @(posedge clk) begin
    if (reset)          err_flags <= '0;
    else if (err_clear) err_flags <= '0;
    else                err_flags <= err_flags | err_set;
  end

endmodule

// File: tb/tb_uart_spi_bridge.sv
// Bench for uart_spi_bridge: an 8-bit mode-0 MSB-first instance and a
// 12-bit mode-3 LSB-first instance driven by one SPI master model.
module tb_uart_spi_bridge;

  localparam int H = 8;  // sclk half period in clk cycles

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   total = 0;
  int   bad   = 0;

  // dut0: DATA_W=8, mode 0, MSB first, fill 0xFF
  logic [7:0]  rxd0;
  logic        rxv0, rdy0, clr0;
  logic [7:0]  txd0;
  logic        txv0, miso0, rxp0, txp0;
  logic [3:0]  txl0, rxl0;
  logic [2:0]  err0;
  // dut3: DATA_W=12, mode 3, LSB first, fill 0
  logic [11:0] rxd3;
  logic        rxv3, rdy3, clr3;
  logic [11:0] txd3;
  logic        txv3, miso3, rxp3, txp3;
  logic [3:0]  txl3, rxl3;
  logic [2:0]  err3;

  // shared SPI master, routed to one DUT at a time
  logic sel, m_cs, m_sclk, m_mosi;
  wire  cs0   = sel ? 1'b1 : m_cs;
  wire  sclk0 = sel ? 1'b0 : m_sclk;
  wire  mosi0 = sel ? 1'b0 : m_mosi;
  wire  cs3   = sel ? m_cs : 1'b1;
  wire  sclk3 = sel ? m_sclk : 1'b1;
  wire  mosi3 = sel ? m_mosi : 1'b0;
  wire  m_miso = sel ? miso3 : miso0;

  uart_spi_bridge #(.DATA_W(8), .FIFO_DEPTH(8), .SPI_MODE(0), .MSB_FIRST(1'b1), .FILL_WORD(8'hFF)) dut0 (
    .clk(clk), .reset(reset), .uart_rx_data(rxd0), .uart_rx_valid(rxv0),
    .uart_tx_data(txd0), .uart_tx_valid(txv0), .uart_tx_ready(rdy0),
    .cs_bar(cs0), .sclk(sclk0), .mosi(mosi0), .miso(miso0),
    .spi_rx_valid(rxp0), .spi_tx_done(txp0), .tx_level(txl0), .rx_level(rxl0),
    .err_flags(err0), .err_clear(clr0));

  uart_spi_bridge #(.DATA_W(12), .FIFO_DEPTH(8), .SPI_MODE(3), .MSB_FIRST(1'b0), .FILL_WORD(12'h000)) dut3 (
    .clk(clk), .reset(reset), .uart_rx_data(rxd3), .uart_rx_valid(rxv3),
    .uart_tx_data(txd3), .uart_tx_valid(txv3), .uart_tx_ready(rdy3),
    .cs_bar(cs3), .sclk(sclk3), .mosi(mosi3), .miso(miso3),
    .spi_rx_valid(rxp3), .spi_tx_done(txp3), .tx_level(txl3), .rx_level(rxl3),
    .err_flags(err3), .err_clear(clr3));

  // reference model state
  int unsigned tx_m0[$], tx_m3[$], rx_m0[$];
  int unsigned exp_got0[$], exp_got3[$], got0[$], got3[$];
  int unsigned mosi_w[$], miso_w[$];
  logic [2:0]  err_m0, err_m3;
  int          exp_p0 = 0, exp_p3 = 0;
  int          n_rxv0 = 0, n_txd0 = 0, n_rxv3 = 0, n_txd3 = 0;

  // pulse counters and UART-side delivery capture
  always @(negedge clk) begin
    if (rxp0) n_rxv0++;
    if (txp0) n_txd0++;
    if (rxp3) n_rxv3++;
    if (txp3) n_txd3++;
    if (txv0 && rdy0) got0.push_back({24'd0, txd0});
    if (txv3 && rdy3) got3.push_back({20'd0, txd3});
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push0(input int unsigned v);
    rxd0 = v[7:0]; rxv0 = 1'b1; tick(1); rxv0 = 1'b0;
    if (tx_m0.size() < 8) tx_m0.push_back(v); else err_m0[0] = 1'b1;
  endtask

  task automatic push3(input int unsigned v);
    rxd3 = v[11:0]; rxv3 = 1'b1; tick(1); rxv3 = 1'b0;
    if (tx_m3.size() < 8) tx_m3.push_back(v); else err_m3[0] = 1'b1;
  endtask

  // SPI master: clocks nbits bits from mosi_w, assembles miso words
  task automatic spi_frame(input bit s, input int w, input int nbits);
    bit cpol = s;
    bit cpha = s;
    bit msb  = !s;
    int unsigned cur_in = 0, cur_out = 0;
    int bi, idx;
    sel = s; m_sclk = cpol; m_cs = 1'b1; m_mosi = 1'b0; tick(4);
    m_cs = 1'b0; tick(10);
    for (int i = 0; i < nbits; i++) begin
      bi  = i % w;
      idx = msb ? (w - 1 - bi) : bi;
      if (bi == 0) begin cur_in = mosi_w[i / w]; cur_out = 0; end
      if (!cpha) begin
        m_mosi = cur_in[idx]; tick(H);
        cur_out[idx] = m_miso; m_sclk = !cpol; tick(H);
        m_sclk = cpol;
      end else begin
        m_sclk = !cpol; m_mosi = cur_in[idx]; tick(H);
        cur_out[idx] = m_miso; m_sclk = cpol; tick(H);
      end
      if (bi == w - 1) miso_w.push_back(cur_out);
    end
    tick(H); m_cs = 1'b1; tick(12);
  endtask

  // Frame plus model: one TX load at frame start and one per completed word
  task automatic run_frame(input bit s, input int nbits, input string tag);
    int w = s ? 12 : 8;
    int nw = nbits / w;
    int unsigned fill = s ? 32'h0 : 32'hFF;
    int unsigned exp_m[$];
    int unsigned v;
    for (int i = 0; i <= nw; i++) begin
      if (s) v = (tx_m3.size() > 0) ? tx_m3.pop_front() : fill;
      else   v = (tx_m0.size() > 0) ? tx_m0.pop_front() : fill;
      exp_m.push_back(v);
    end
    miso_w = {};
    spi_frame(s, w, nbits);
    chk({tag, " miso count"}, miso_w.size(), nw);
    for (int i = 0; i < nw && i < miso_w.size(); i++)
      chk($sformatf("%s miso%0d", tag, i), miso_w[i], exp_m[i]);
    for (int i = 0; i < nw; i++) begin
      if (s) exp_got3.push_back(mosi_w[i]);
      else if (rdy0) exp_got0.push_back(mosi_w[i]);
      else if (rx_m0.size() < 8) rx_m0.push_back(mosi_w[i]);
      else err_m0[1] = 1'b1;
    end
    if (s) exp_p3 += nw; else exp_p0 += nw;
  endtask

  task automatic check_got(input string tag);
    chk({tag, " got0 size"}, got0.size(), exp_got0.size());
    for (int i = 0; i < exp_got0.size() && i < got0.size(); i++)
      chk($sformatf("%s got0[%0d]", tag, i), got0[i], exp_got0[i]);
    chk({tag, " got3 size"}, got3.size(), exp_got3.size());
    for (int i = 0; i < exp_got3.size() && i < got3.size(); i++)
      chk($sformatf("%s got3[%0d]", tag, i), got3[i], exp_got3[i]);
    got0 = {}; exp_got0 = {}; got3 = {}; exp_got3 = {};
  endtask

  task automatic check_status0(input string tag);
    chk({tag, " txl0"}, txl0, tx_m0.size());
    chk({tag, " rxl0"}, rxl0, rx_m0.size());
    chk({tag, " err0"}, err0, err_m0);
    chk({tag, " rxv0 pulses"}, n_rxv0, exp_p0);
    chk({tag, " txd0 pulses"}, n_txd0, exp_p0);
  endtask

  initial begin
    int k, n;
    reset = 1'b1;
    rxd0 = '0; rxv0 = 1'b0; rdy0 = 1'b1; clr0 = 1'b0;
    rxd3 = '0; rxv3 = 1'b0; rdy3 = 1'b1; clr3 = 1'b0;
    sel = 1'b0; m_cs = 1'b1; m_sclk = 1'b0; m_mosi = 1'b0;
    err_m0 = '0; err_m3 = '0;
    tick(5);
    reset = 1'b0;
    tick(2);

    // reset state
    chk("rst miso0", miso0, 1'b0);
    chk("rst txv0", txv0, 1'b0);
    chk("rst pulse0", {rxp0, txp0}, 2'b00);
    check_status0("rst");
    chk("rst txl3", txl3, 0);
    chk("rst err3", err3, 0);
    chk("rst miso3", miso3, 1'b0);

    // two back-to-back words, mode 0
    push0(32'hA5); push0(32'h3C);
    mosi_w = {32'h81, 32'h7E};
    run_frame(1'b0, 16, "b2b");
    check_status0("b2b");
    check_got("b2b");

    // empty TX FIFO shifts FILL_WORD
    mosi_w = {$urandom_range(0, 255)};
    run_frame(1'b0, 8, "fill");
    check_status0("fill");
    check_got("fill");

    // TX overflow and clear
    for (int i = 0; i < 9; i++) push0($urandom_range(0, 255));
    tick(2);
    check_status0("txovf");
    clr0 = 1'b1; tick(1); clr0 = 1'b0; err_m0 = '0; tick(1);
    chk("txovf clear err0", err0, err_m0);

    // RX overflow with transmitter stalled, then ordered drain
    rdy0 = 1'b0;
    mosi_w = {};
    for (int i = 0; i < 9; i++) mosi_w.push_back($urandom_range(0, 255));
    run_frame(1'b0, 72, "rxovf");
    check_status0("rxovf");
    rdy0 = 1'b1;
    while (rx_m0.size() > 0) exp_got0.push_back(rx_m0.pop_front());
    tick(20);
    check_status0("drain");
    check_got("drain");
    clr0 = 1'b1; tick(1); clr0 = 1'b0; err_m0 = '0; tick(1);

    // abort after 3 bits, then a clean frame
    push0($urandom_range(0, 255));
    mosi_w = {$urandom_range(0, 255)};
    run_frame(1'b0, 3, "abort");
    err_m0[2] = 1'b1;
    check_status0("abort");
    clr0 = 1'b1; tick(1); clr0 = 1'b0; err_m0 = '0; tick(1);
    mosi_w = {$urandom_range(0, 255)};
    run_frame(1'b0, 8, "post");
    check_status0("post");
    check_got("post");

    // randomized traffic
    for (int it = 0; it < 4; it++) begin
      k = $urandom_range(0, 3);
      n = $urandom_range(1, 3);
      for (int i = 0; i < k; i++) push0($urandom_range(0, 255));
      mosi_w = {};
      for (int i = 0; i < n; i++) mosi_w.push_back($urandom_range(0, 255));
      run_frame(1'b0, n * 8, $sformatf("rnd%0d", it));
      check_status0($sformatf("rnd%0d", it));
      check_got($sformatf("rnd%0d", it));
    end

    // mode 3, 12-bit, LSB first
    push3(32'h5A3);
    mosi_w = {32'h5A3, $urandom_range(0, 4095)};
    run_frame(1'b1, 24, "m3");
    tick(4);
    chk("m3 rx pulses", n_rxv3, exp_p3);
    chk("m3 tx pulses", n_txd3, exp_p3);
    chk("m3 txl3", txl3, tx_m3.size());
    chk("m3 rxl3", rxl3, 0);
    chk("m3 err3", err3, err_m3);
    check_got("m3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
